// File: rtl/demux4_pkg.sv
// Shared constants and types for the 1-to-4 burst demux path.
package demux4_pkg;

    localparam int unsigned NUM_CH        = 4;
    localparam int unsigned SEL_W         = 2;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_BURST_LEN = 4;
    localparam int unsigned DEF_CNT_W     = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rtr_state_t;

endpackage

// File: rtl/demux4_chan_fifo.sv
// Two-entry per-channel FIFO; head entry is always mem0, so the output is a flop.
module demux4_chan_fifo #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    logic [1:0]        count;
    logic [DATA_W-1:0] mem0;
    logic [DATA_W-1:0] mem1;

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= push_data;
                    else               mem1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem0;

endmodule

// File: rtl/demux4_burst_router.sv
// Routes whole input bursts to one of four buffered output channels chosen on beat 0.
module demux4_burst_router
    import demux4_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     burst_busy,
    output logic [NUM_CH*CNT_W-1:0]  beat_cnt
);

    localparam int unsigned    IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    rtr_state_t       state, state_nxt;
    logic [SEL_W-1:0] cur_sel, cur_sel_nxt;
    logic [IDX_W-1:0] beat_idx, beat_idx_nxt;
    logic [SEL_W-1:0] eff_sel;
    logic             accept;
    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] ch_empty;

    // Ready depends only on registered state and in_sel, never on out_ready.
    always_comb begin
        eff_sel  = (state == IDLE) ? in_sel : cur_sel;
        in_ready = !ch_full[eff_sel];
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_sel  <= '0;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            cur_sel  <= cur_sel_nxt;
            beat_idx <= beat_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_sel_nxt  = cur_sel;
        beat_idx_nxt = beat_idx;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cur_sel_nxt = in_sel;
                    if (BURST_LEN > 1) begin
                        state_nxt    = BURST;
                        beat_idx_nxt = IDX_W'(1);
                    end else begin
                        beat_idx_nxt = '0;
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    if (beat_idx == LAST_IDX) begin
                        state_nxt    = IDLE;
                        beat_idx_nxt = '0;
                    end else begin
                        beat_idx_nxt = beat_idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign burst_busy = (state == BURST);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             push;
        logic             pop;
        logic [CNT_W-1:0] cnt;

        assign push = accept && (eff_sel == SEL_W'(ch));
        assign pop  = !ch_empty[ch] && out_ready[ch];

        demux4_chan_fifo #(.DATA_W(DATA_W)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push),
            .push_data (in_data),
            .pop       (pop),
            .full      (ch_full[ch]),
            .empty     (ch_empty[ch]),
            .head      (out_data[ch*DATA_W +: DATA_W])
        );

        // Saturating accepted-beat counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                     cnt <= '0;
            else if (push && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end

        assign out_valid[ch]                 = !ch_empty[ch];
        assign beat_cnt[ch*CNT_W +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_demux4_burst_router.sv
// Directed plus randomized bench for demux4_burst_router against a queue-based model.
module tb_demux4_burst_router;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned NCH       = 4;
    localparam int          CNT_MAX   = 7;

    logic                    clk;
    logic                    rst_n;
    logic [DATA_W-1:0]       in_data;
    logic [1:0]              in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [NCH*DATA_W-1:0]   out_data;
    logic [NCH-1:0]          out_valid;
    logic [NCH-1:0]          out_ready;
    logic                    burst_busy;
    logic [NCH*CNT_W-1:0]    beat_cnt;

    demux4_burst_router #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .burst_busy (burst_busy),
        .beat_cnt   (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer contents as queues, burst progress as a beat count.
    logic [DATA_W-1:0] mq [NCH][$];
    int  mcnt [NCH];
    bit  m_in_burst;
    int  m_sel;
    int  m_beats;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
        m_in_burst = 1'b0;
        m_sel      = 0;
        m_beats    = 0;
    endtask

    function automatic int model_eff(input int sel);
        return m_in_burst ? m_sel : sel;
    endfunction

    task automatic check_outputs(input string tag);
        int e;
        e = model_eff(int'(in_sel));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq[e].size() < 2));
        chk({tag, "_busy"}, 32'(burst_busy), 32'(m_in_burst));
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
            if (mq[i].size() > 0)
                chk($sformatf("%s_data%0d", tag, i), 32'(out_data[i*DATA_W +: DATA_W]), 32'(mq[i][0]));
            chk($sformatf("%s_cnt%0d", tag, i), 32'(beat_cnt[i*CNT_W +: CNT_W]), 32'(mcnt[i]));
        end
    endtask

    // One clock cycle: drive after negedge, check, advance model at posedge.
    task automatic cycle(input string tag, input bit v, input int sel,
                         input logic [DATA_W-1:0] d, input logic [NCH-1:0] rdy,
                         output bit acc);
        bit pop_m [NCH];
        int e;
        in_valid  = v;
        in_sel    = 2'(sel);
        in_data   = d;
        out_ready = rdy;
        #1;
        check_outputs(tag);
        e   = model_eff(sel);
        acc = v && (mq[e].size() < 2);
        for (int i = 0; i < NCH; i++) pop_m[i] = rdy[i] && (mq[i].size() > 0);
        @(posedge clk);
        for (int i = 0; i < NCH; i++) if (pop_m[i]) void'(mq[i].pop_front());
        if (acc) begin
            mq[e].push_back(d);
            if (mcnt[e] < CNT_MAX) mcnt[e]++;
            if (!m_in_burst) begin
                m_sel      = sel;
                m_beats    = 1;
                m_in_burst = (BURST_LEN > 1);
            end else begin
                m_beats++;
                if (m_beats == BURST_LEN) m_in_burst = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        bit a;
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 0, '0, 4'hF, a);
    endtask

    initial begin
        bit acc;
        int sent;
        int cyc;
        int first_reject;
        int sels [4];
        logic [NCH-1:0] rdy;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");
        chk("reset_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single burst to ch2, consumers always ready.
        for (int k = 0; k < 4; k++) cycle("t1", 1'b1, 2, 8'(8'hA0 + k), 4'hF, acc);
        idle("t1_drain", 2);
        chk("t1_cnt2", 32'(beat_cnt[2*CNT_W +: CNT_W]), 32'd4);

        // in_sel wanders mid-burst; every beat still goes to ch1.
        sels = '{1, 3, 0, 2};
        for (int k = 0; k < 4; k++) cycle("t2", 1'b1, sels[k], 8'(8'hB0 + k), 4'hF, acc);
        idle("t2_drain", 2);
        chk("t2_cnt1", 32'(beat_cnt[1*CNT_W +: CNT_W]), 32'd4);

        // ch0 stalled: ready drops after two beats, then drains in order.
        sent = 0; cyc = 0; first_reject = -1;
        while (sent < 4 && cyc < 20) begin
            rdy = (cyc < 6) ? 4'b1110 : 4'b1111;
            cycle("t3", 1'b1, 0, 8'(8'hC0 + sent), rdy, acc);
            if (acc) sent++;
            else if (first_reject < 0) first_reject = cyc;
            cyc++;
        end
        chk("t3_sent", 32'(sent), 32'd4);
        chk("t3_first_reject", 32'(first_reject), 32'd2);
        idle("t3_drain", 3);

        // Fill ch3 and hold it; ch0 bursts must still flow at full rate.
        sent = 0; cyc = 0;
        while (sent < 4 && cyc < 20) begin
            rdy = (cyc < 3) ? 4'b1111 : 4'b0111;
            cycle("t4a", 1'b1, 3, 8'(8'hD0 + sent), rdy, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("t4_ch3_sent", 32'(sent), 32'd4);
        sent = 0;
        for (int k = 0; k < 4; k++) begin
            cycle("t4b", 1'b1, 0, 8'(8'hE0 + k), 4'b0111, acc);
            if (acc) sent++;
        end
        chk("t4_ch0_rate", 32'(sent), 32'd4);
        chk("t4_ch3_held", 32'(out_valid[3]), 32'd1);
        idle("t4_drain", 3);

        // Reset mid-burst with beats buffered.
        for (int k = 0; k < 2; k++) cycle("t5a", 1'b1, 1, 8'(8'h50 + k), 4'h0, acc);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(burst_busy), 32'd0);
        chk("t5_cnt", 32'(beat_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle("t5b", 1'b1, (k == 0) ? 2 : 1, 8'(8'h60 + k), 4'hF, acc);
        idle("t5_drain", 2);
        chk("t5_cnt2", 32'(beat_cnt[2*CNT_W +: CNT_W]), 32'd4);

        // Counter saturation on ch1.
        for (int k = 0; k < 12; k++) cycle("t6", 1'b1, 1, 8'(k), 4'hF, acc);
        idle("t6_drain", 2);
        chk("t6_sat", 32'(beat_cnt[1*CNT_W +: CNT_W]), 32'd7);

        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            cycle("rnd", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom), acc);
            if (k == 200) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
